// File: rtl/seq_encoder_4to2_if.sv
// Request/response bundle for seq_encoder_4to2.
// slave  : the encoder side (captures req_in, presents code).
// master : the request generator / code consumer side.
interface seq_encoder_4to2_if;
  logic [3:0] req_in;
  logic       req_load;
  logic       in_ready;
  logic [1:0] code;
  logic       out_valid;
  logic       out_ready;
  logic       last;
  logic [3:0] pending;

  modport slave (
    input  req_in, req_load, out_ready,
    output in_ready, code, out_valid, last, pending
  );

  modport master (
    output req_in, req_load, out_ready,
    input  in_ready, code, out_valid, last, pending
  );
endinterface

// File: rtl/seq_encoder_4to2.sv
// Registered 4-to-2 encoder: captures a 4-line request vector and drains it
// one 2-bit code per valid/ready transfer, in priority order set by
// HIGH_FIRST (0: line 0 first, 1: line 3 first).
module seq_encoder_4to2 #(
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  seq_encoder_4to2_if.slave         bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SERVE = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_pending;
  logic [3:0] w_pending_nxt;
  logic [1:0] w_code;
  logic       w_single;
  logic       w_serve;

  assign w_serve = (r_state == S_SERVE);

  // Priority encode of the pending mask; an empty mask yields 00.
  always_comb begin
    w_code = 2'b00;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 4; i++)
        if (r_pending[i]) w_code = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--)
        if (r_pending[i]) w_code = 2'(i);
    end
  end

  // One-hot detect: exactly one line still pending.
  assign w_single = (r_pending != 4'b0000) &&
                    ((r_pending & (r_pending - 4'd1)) == 4'b0000);

  // Next-state and next-pending; outputs depend only on r_state/r_pending,
  // so req_load/out_ready only ever reach registers.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_load) begin
          w_pending_nxt = bus.req_in;
          w_state_nxt   = (bus.req_in != 4'b0000) ? S_SERVE : S_IDLE;
        end
      end
      S_SERVE: begin
        if (bus.out_ready) begin
          w_pending_nxt = r_pending & ~(4'b0001 << w_code);
          if (w_single) w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_pending_nxt = 4'b0000;
      end
    endcase
  end

  // State and pending registers; reset wins over load or transfer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign bus.in_ready  = ~w_serve;
  assign bus.out_valid = w_serve;
  assign bus.code      = w_code;
  assign bus.last      = w_serve & w_single;
  assign bus.pending   = r_pending;

endmodule

// File: tb/tb_seq_encoder_4to2.sv
// Directed bench: two encoders (low-first and high-first) driven in lockstep
// from the same stimulus, each checked against hand-computed codes.
module tb_seq_encoder_4to2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic       req_load;
  logic       out_ready;

  int total = 0;
  int bad   = 0;
  int nvld;

  seq_encoder_4to2_if bl ();
  seq_encoder_4to2_if bh ();

  assign bl.req_in    = req_in;
  assign bl.req_load  = req_load;
  assign bl.out_ready = out_ready;
  assign bh.req_in    = req_in;
  assign bh.req_load  = req_load;
  assign bh.out_ready = out_ready;

  seq_encoder_4to2 #(.HIGH_FIRST(1'b0)) u_lo (.i_clk(clk), .i_rst_n(rst_n), .bus(bl));
  seq_encoder_4to2 #(.HIGH_FIRST(1'b1)) u_hi (.i_clk(clk), .i_rst_n(rst_n), .bus(bh));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    req_in   = v;
    req_load = 1'b1;
    tick();
    req_load = 1'b0;
  endtask

  logic [3:0] sv_vec [3] = '{4'b0001, 4'b0010, 4'b1000};
  logic [1:0] sv_code[3] = '{2'b00, 2'b01, 2'b11};

  initial begin
    rst_n = 1'b0; req_load = 1'b1; req_in = 4'b1111; out_ready = 1'b0;
    #1;
    tick(); tick();
    chk("rst_in_ready",  8'(bl.in_ready),  8'd1);
    chk("rst_out_valid", 8'(bl.out_valid), 8'd0);
    chk("rst_code",      8'(bl.code),      8'd0);
    chk("rst_last",      8'(bl.last),      8'd0);
    chk("rst_pending",   8'(bl.pending),   8'd0);
    chk("rst_h_valid",   8'(bh.out_valid), 8'd0);
    chk("rst_h_pending", 8'(bh.pending),   8'd0);
    rst_n = 1'b1; req_load = 1'b0; req_in = 4'b0000;
    tick();

    // single line
    out_ready = 1'b1;
    load(4'b0100);
    chk("one_0100_valid", 8'(bl.out_valid), 8'd1);
    chk("one_0100_code",  8'(bl.code),      8'd2);
    chk("one_0100_last",  8'(bl.last),      8'd1);
    chk("one_0100_hcode", 8'(bh.code),      8'd2);
    tick();
    chk("one_0100_idle",  8'(bl.out_valid), 8'd0);
    chk("one_0100_rdy",   8'(bl.in_ready),  8'd1);
    for (int i = 0; i < 3; i++) begin
      load(sv_vec[i]);
      chk("one_code",  8'(bl.code),      8'(sv_code[i]));
      chk("one_last",  8'(bl.last),      8'd1);
      chk("one_hcode", 8'(bh.code),      8'(sv_code[i]));
      tick();
      chk("one_idle",  8'(bl.out_valid), 8'd0);
    end

    // full vector, both orders in lockstep
    load(4'b1111);
    for (int k = 0; k < 4; k++) begin
      chk("full_lo_valid", 8'(bl.out_valid), 8'd1);
      chk("full_lo_code",  8'(bl.code),      8'(k));
      chk("full_lo_last",  8'(bl.last),      8'(k == 3));
      chk("full_hi_code",  8'(bh.code),      8'(3 - k));
      chk("full_hi_last",  8'(bh.last),      8'(k == 3));
      tick();
    end
    chk("full_lo_done",  8'(bl.out_valid), 8'd0);
    chk("full_hi_done",  8'(bh.out_valid), 8'd0);
    chk("full_lo_rdy",   8'(bl.in_ready),  8'd1);

    // back-pressure
    out_ready = 1'b0;
    nvld = 0;
    load(4'b1010);
    for (int k = 0; k < 3; k++) begin
      if (bl.out_valid) nvld++;
      chk("bp_hold_code", 8'(bl.code),    8'd1);
      chk("bp_hold_pend", 8'(bl.pending), 8'hA);
      chk("bp_hold_last", 8'(bl.last),    8'd0);
      chk("bp_hold_hcode", 8'(bh.code),   8'd3);
      tick();
    end
    out_ready = 1'b1;
    if (bl.out_valid) nvld++;
    chk("bp_code0", 8'(bl.code), 8'd1);
    tick();
    if (bl.out_valid) nvld++;
    chk("bp_code1", 8'(bl.code), 8'd3);
    chk("bp_last1", 8'(bl.last), 8'd1);
    chk("bp_hcode1", 8'(bh.code), 8'd1);
    tick();
    if (bl.out_valid) nvld++;
    chk("bp_idle",   8'(bl.out_valid), 8'd0);
    chk("bp_nvalid", 8'(nvld),         8'd5);

    // load during SERVE is ignored, including on the final transfer
    load(4'b0110);
    chk("ld_code0", 8'(bl.code), 8'd1);
    req_in = 4'b0001; req_load = 1'b1;
    tick();
    chk("ld_code1", 8'(bl.code),    8'd2);
    chk("ld_pend1", 8'(bl.pending), 8'h4);
    chk("ld_last1", 8'(bl.last),    8'd1);
    tick();
    req_load = 1'b0;
    chk("ld_idle",  8'(bl.out_valid), 8'd0);
    chk("ld_pend",  8'(bl.pending),   8'd0);
    tick();
    chk("ld_still_idle", 8'(bl.out_valid), 8'd0);

    // all-zero load
    load(4'b0000);
    chk("zero_valid", 8'(bl.out_valid), 8'd0);
    chk("zero_rdy",   8'(bl.in_ready),  8'd1);
    chk("zero_pend",  8'(bl.pending),   8'd0);

    // reset mid-drain
    load(4'b1111);
    chk("mr_code0", 8'(bl.code), 8'd0);
    tick();
    chk("mr_pend1", 8'(bl.pending), 8'hE);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_pend",   8'(bl.pending),   8'd0);
    chk("mr_valid",  8'(bl.out_valid), 8'd0);
    chk("mr_rdy",    8'(bl.in_ready),  8'd1);
    chk("mr_hpend",  8'(bh.pending),   8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_quiet", 8'(bl.out_valid | bh.out_valid), 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_encoder_4to2.md
# seq_encoder_4to2

Registered 4-to-2 encoder that converts a captured 4-line request vector back into 2-bit codes, the inverse of the team's combinational 2-to-4 decoder. Line 0 maps to code 00, line 1 to 01, line 2 to 10, and line 3 to 11. A captured vector with several lines set is drained one code per accepted transfer, in priority order, over a valid/ready output handshake. The block sits between request-generating logic and any consumer that needs a compact 2-bit index, for example a 2-to-4 decoder driving select lines downstream.

## Interface
- HIGH_FIRST, default 0: 0 serves the lowest-numbered set line first (0→3); 1 serves the highest first (3→0).
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- req_in  input  4  request lines; bit i set means line i active; sampled only on an accepted load.
- req_load  input  1  capture strobe for req_in.
- in_ready  output  1  block can accept a load this cycle.
- code  output  2  encoded index of the current highest-priority pending line.
- out_valid  output  1  code is valid.
- out_ready  input  1  consumer accepts code.
- last  output  1  qualifies code; set when the presented code is the only pending line.
- pending  output  4  mask of lines captured but not yet served.

## Operation
- State machine with two states: IDLE and SERVE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - Load is accepted when req_load=1; pending ← req_in.
  - Next state is SERVE if req_in≠0, otherwise IDLE. An all-zero load is accepted, produces no output, and leaves pending=0.
- **SERVE**
  - in_ready=0, out_valid=1.
  - code = priority encode of pending per HIGH_FIRST.
  - last = 1 exactly when pending has a single bit set.
  - req_load is ignored and req_in is not sampled.
- **Transfer**: occurs when out_valid & out_ready at a rising edge.
  - The bit for the presented code is cleared in pending.
  - If that bit was the last one (last=1), next state is IDLE; otherwise stay in SERVE.
- **Stability**: while out_valid=1 and out_ready=0, code, last and pending hold constant. pending changes only on an accepted load or a transfer.
- **Combinational rules**
  - code, last, out_valid and in_ready are pure functions of state and pending.
  - There is no combinational path from out_ready or req_load to any output.
- **Width rules**
  - code is exactly 2 bits.
  - pending popcount never increases while in SERVE.
  - When pending=0, code is driven 00.
- **Reset**
  - rst_n=0 at a rising edge forces state=IDLE and pending=0.
  - Reset values: in_ready=1, out_valid=0, code=00, last=0, pending=0000.
  - Reset mid-drain discards all pending lines; no further codes are emitted.
  - Reset takes priority over a simultaneous load or transfer.

## Timing
- Load accepted at edge N → out_valid=1 with the first code from edge N+1 onward.
- Throughput is one code per cycle while out_ready is held at 1.
- A k-bit vector (k=1..4) with out_ready held high:
  - out_valid is high for exactly k cycles, at N+1 … N+k.
  - out_valid drops and in_ready rises at edge N+k+1.
  - The earliest next load is at edge N+k+1.
- Back-pressure: each cycle with out_ready=0 extends the drain by one cycle; no code is lost or duplicated.
- An all-zero load at edge N leaves in_ready=1 and out_valid=0 at N+1.
- req_load asserted during SERVE has no effect, including in the final transfer cycle. The load must be re-presented once in_ready=1.

## Test plan
- **Reset values**: hold rst_n=0 for 2 cycles with req_load=1 and req_in=1111 → in_ready=1, out_valid=0, code=00, last=0, pending=0000.
- **Single line, low-first**: HIGH_FIRST=0, load 0100, out_ready=1 → one cycle with code=10 and last=1, then IDLE. Repeat for 0001/0010/1000 → codes 00, 01, 11, each with last=1.
- **Full vector, both orders**: load 1111 with out_ready=1.
  - HIGH_FIRST=0 → codes 00, 01, 10, 11 on consecutive cycles; last=1 only on 11.
  - HIGH_FIRST=1 → codes 11, 10, 01, 00; last=1 only on 00.
- **Back-pressure**: load 1010 (HIGH_FIRST=0), out_ready=0 for 3 cycles → code=01 held stable with pending=1010. Raise out_ready → codes 01 then 11, then IDLE. Total out_valid cycles = 5.
- **Load rules**:
  - req_load=1 with req_in=0001 during SERVE of 0110 → ignored; only codes 01 and 10 are emitted.
  - All-zero load → no out_valid and in_ready stays 1.
- **Mid-operation reset**: load 1111, accept one code (00), then apply rst_n=0 for one cycle → pending=0000, out_valid=0, in_ready=1, and no further codes are emitted.
